// File: rtl/uio_bus_sched.sv
`default_nettype none
// ============================================================================
// Module   : uio_bus_sched
// Purpose  : Round-robin burst scheduler sharing the 8-bit uio pad bus among
//            NREQ requesters, with bus-release turnaround on direction change.
// Revision : 1.0 - initial release
// ============================================================================
module uio_bus_sched #(
    parameter int NREQ       = 4,
    parameter int MAX_BURST  = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     dir,
    input  logic [8*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          rdata,
    input  logic [7:0]          uio_in,
    output logic [7:0]          uio_out,
    output logic [7:0]          uio_oe
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int TURN_W = 2;
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [TURN_W-1:0] C_TURN      = TURN_W'(TURNAROUND);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]    r_owner, w_owner_nxt;
    logic                r_dir_q, w_dir_q_nxt;
    logic                r_last_dir, w_last_dir_nxt;
    logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
    logic [TURN_W-1:0]   r_turn, w_turn_nxt;

    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_win_next;
    logic                w_own_req;
    logic [NREQ-1:0]     w_owner_oh;
    logic [7:0]          w_wbyte;

    // Rotating priority search starting at r_ptr.
    always_comb begin : p_arb
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_idx = (int'(r_ptr) + i) % NREQ;
            if (!w_found && req[v_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[PTR_W-1:0];
            end
        end
    end

    assign w_win_next = (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_own_req  = req[r_owner];
    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_wbyte    = wdata[{r_owner, 3'b000} +: 8];

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_dir_q_nxt    = r_dir_q;
        w_last_dir_nxt = r_last_dir;
        w_beat_nxt     = r_beat;
        w_turn_nxt     = r_turn;
        case (r_state)
            S_IDLE: begin
                if (ena && w_found) begin
                    w_owner_nxt = w_win;
                    w_dir_q_nxt = dir[w_win];
                    w_ptr_nxt   = w_win_next;
                    w_beat_nxt  = '0;
                    if ((TURNAROUND > 0) && (dir[w_win] != r_last_dir)) begin
                        w_state_nxt = S_TURN;
                        w_turn_nxt  = C_TURN;
                    end else begin
                        w_state_nxt    = S_BUSY;
                        w_last_dir_nxt = dir[w_win];
                    end
                end
            end
            S_TURN: begin
                if (!ena) begin
                    w_state_nxt = S_IDLE;
                end else if (r_turn <= TURN_W'(1)) begin
                    w_state_nxt    = S_BUSY;
                    w_last_dir_nxt = r_dir_q;
                    w_turn_nxt     = '0;
                end else begin
                    w_turn_nxt = r_turn - 1'b1;
                end
            end
            S_BUSY: begin
                // A beat acked this cycle still completes even when ena drops.
                if (!ena || !w_own_req || (r_beat == C_LAST_BEAT)) begin
                    w_state_nxt = S_IDLE;
                end
                if (w_own_req) begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_dir_q    <= 1'b0;
            r_last_dir <= 1'b0;
            r_beat     <= '0;
            r_turn     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_dir_q    <= w_dir_q_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_beat     <= w_beat_nxt;
            r_turn     <= w_turn_nxt;
        end
    end

    always_comb begin
        gnt     = '0;
        ack     = '0;
        uio_oe  = 8'h00;
        uio_out = 8'h00;
        if (r_state != S_IDLE) begin
            gnt = w_owner_oh;
        end
        if (r_state == S_BUSY) begin
            ack     = w_own_req ? w_owner_oh : '0;
            uio_oe  = {8{r_dir_q}};
            uio_out = r_dir_q ? w_wbyte : 8'h00;
        end
    end

    assign rdata = uio_in;

endmodule
`default_nettype wire
